turn_arbiter: RTL and testbench



---
 rtl/turn_arbiter_if.sv | 32 +++
 rtl/turn_arbiter.sv | 127 ++++++++++++
 tb/tb_turn_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/turn_arbiter_if.sv
// Board/AI/game_fsm handshake bundle for turn_arbiter.
// master = environment side, slave = arbiter side.
interface turn_arbiter_if;
  logic       new_game;
  logic [3:0] p_tick;
  logic       p_confirm;
  logic [3:0] ai_tick;
  logic       ai_done;
  logic [1:0] winner;
  logic       ai_start;
  logic       mv_valid;
  logic [3:0] mv_pos;
  logic [1:0] mv_who;
  logic       player_turn;
  logic [3:0] move_cnt;
  logic       game_over;
  logic       err_illegal;
  logic       p_timeout;
  logic       ai_fault;

  modport master (
    output new_game, p_tick, p_confirm, ai_tick, ai_done, winner,
    input  ai_start, mv_valid, mv_pos, mv_who, player_turn, move_cnt,
           game_over, err_illegal, p_timeout, ai_fault
  );

  modport slave (
    input  new_game, p_tick, p_confirm, ai_tick, ai_done, winner,
    output ai_start, mv_valid, mv_pos, mv_who, player_turn, move_cnt,
           game_over, err_illegal, p_timeout, ai_fault
  );
endinterface

// File: rtl/turn_arbiter.sv
// Turn sequencer between player input, ai_agent and game_fsm: legality via a
// shadow occupancy mask, player timeout / AI watchdog with lowest-free fallback.
module turn_arbiter #(
  parameter int PLAYER_FIRST = 1,
  parameter int P_TIMEOUT    = 1000,
  parameter int AI_TIMEOUT   = 200,
  parameter int SETTLE       = 2
) (
  input logic          clk,
  input logic          rst,
  turn_arbiter_if.slave bus
);
  typedef enum logic [2:0] {P_WAIT, AI_REQ, AI_WAIT, ISSUE, SETTLING, DONE} state_t;
  typedef struct packed {
    logic [3:0] pos;
    logic [1:0] who;
  } move_t;

  localparam logic [1:0]    WHO_P = 2'b01;
  localparam logic [1:0]    WHO_A = 2'b10;
  localparam int            SW    = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] S_LIM = SW'(SETTLE - 1);
  localparam logic [15:0]   P_LIM = 16'(P_TIMEOUT - 1);
  localparam logic [15:0]   A_LIM = 16'(AI_TIMEOUT - 1);
  localparam state_t        START = (PLAYER_FIRST != 0) ? P_WAIT : AI_REQ;

  state_t        st, nxt;
  logic [15:0]   timer_q, timer_d;
  logic [SW-1:0] set_q, set_d;
  logic [8:0]    mask_q, mask_d;
  logic [3:0]    cnt_q, cnt_d;
  move_t         pend_q, pend_d, mv_q, mv_d;
  logic ai_start_q, ai_start_d, mv_valid_q, mv_valid_d, pt_q, pt_d, go_q, go_d;
  logic err_q, err_d, pto_q, pto_d, fault_q, fault_d;

  // Indices 9..15 read as occupied so one lookup covers both legality rules.
  logic [15:0] occ;
  logic        p_legal, ai_legal;
  logic [3:0]  free;

  assign occ      = {7'h7f, mask_q};
  assign p_legal  = !occ[bus.p_tick];
  assign ai_legal = !occ[bus.ai_tick];

  always_comb begin
    free = 4'd0;
    for (int i = 8; i >= 0; i--)
      if (!mask_q[i]) free = 4'(i);
  end

  always_comb begin
    nxt = st;  timer_d = 16'd0;  set_d = set_q;  mask_d = mask_q;  cnt_d = cnt_q;
    pend_d = pend_q;  mv_d = mv_q;
    mv_valid_d = 1'b0;  err_d = 1'b0;  pto_d = 1'b0;  fault_d = 1'b0;
    case (st)
      P_WAIT: begin
        timer_d = timer_q + 16'd1;
        if (bus.p_confirm && p_legal) begin
          nxt = ISSUE;  pend_d.pos = bus.p_tick;  pend_d.who = WHO_P;
        end else begin
          err_d = bus.p_confirm;
          if (P_TIMEOUT != 0 && timer_q == P_LIM) begin
            nxt = ISSUE;  pend_d.pos = free;  pend_d.who = WHO_P;  pto_d = 1'b1;
          end
        end
      end
      // Holds an extra cycle when entered straight from reset so ai_start still pulses.
      AI_REQ: if (ai_start_q) nxt = AI_WAIT;
      AI_WAIT: begin
        timer_d = timer_q + 16'd1;
        if (bus.ai_done || timer_q == A_LIM) begin
          nxt = ISSUE;  pend_d.who = WHO_A;
          if (bus.ai_done && ai_legal) pend_d.pos = bus.ai_tick;
          else begin pend_d.pos = free;  fault_d = 1'b1; end
        end
      end
      ISSUE: begin
        mv_valid_d = 1'b1;  mv_d = pend_q;
        mask_d = mask_q | (9'd1 << pend_q.pos);
        cnt_d  = cnt_q + 4'd1;
        set_d  = '0;  nxt = SETTLING;
      end
      SETTLING: begin
        if (set_q == S_LIM) begin
          if (bus.winner != 2'b00 || cnt_q == 4'd9) nxt = DONE;
          else if (mv_q.who == WHO_P)              nxt = AI_REQ;
          else                                     nxt = P_WAIT;
        end else set_d = set_q + SW'(1);
      end
      DONE:    nxt = DONE;
      default: nxt = START;
    endcase
    ai_start_d = (nxt == AI_REQ) && !ai_start_q;
    pt_d       = (nxt == P_WAIT);
    go_d       = (nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.new_game) st <= START;
    else                     st <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.new_game) begin
      timer_q <= '0;  set_q <= '0;  mask_q <= '0;  cnt_q <= '0;
      pend_q <= '0;  mv_q <= '0;
      ai_start_q <= 1'b0;  mv_valid_q <= 1'b0;  pt_q <= 1'(PLAYER_FIRST != 0);
      go_q <= 1'b0;  err_q <= 1'b0;  pto_q <= 1'b0;  fault_q <= 1'b0;
    end else begin
      timer_q <= timer_d;  set_q <= set_d;  mask_q <= mask_d;  cnt_q <= cnt_d;
      pend_q <= pend_d;  mv_q <= mv_d;
      ai_start_q <= ai_start_d;  mv_valid_q <= mv_valid_d;  pt_q <= pt_d;
      go_q <= go_d;  err_q <= err_d;  pto_q <= pto_d;  fault_q <= fault_d;
    end
  end

  assign bus.ai_start    = ai_start_q;
  assign bus.mv_valid    = mv_valid_q;
  assign bus.mv_pos      = mv_q.pos;
  assign bus.mv_who      = mv_q.who;
  assign bus.player_turn = pt_q;
  assign bus.move_cnt    = cnt_q;
  assign bus.game_over   = go_q;
  assign bus.err_illegal = err_q;
  assign bus.p_timeout   = pto_q;
  assign bus.ai_fault    = fault_q;
endmodule

// File: tb/tb_turn_arbiter.sv
// Directed bench for turn_arbiter: a turn-level behavioural model checked every
// cycle, plus literal expectations for latencies, fallback cells and game end.
module tb_turn_arbiter;
  localparam int P_TO = 8, AI_TO = 5, SET = 2;
  localparam int S_MV = 0, S_AS = 1, S_ERR = 2, S_PTO = 3, S_FLT = 4, S_PT = 5, S_GO = 6;

  logic clk = 1'b0, rst = 1'b1;
  int   checks = 0, failures = 0;
  bit   active = 1'b0;

  turn_arbiter_if bus ();
  turn_arbiter #(.PLAYER_FIRST(1), .P_TIMEOUT(P_TO), .AI_TIMEOUT(AI_TO), .SETTLE(SET))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [8:0] occ;
  bit e_as, e_mv, e_err, e_pto, e_flt, e_pt, e_go;
  int e_pos, e_who, e_cnt;

  function automatic bit legal(input int c);
    return (c < 9) && !occ[c];
  endfunction

  function automatic int lowest();
    for (int i = 0; i < 9; i++) if (!occ[i]) return i;
    return 0;
  endfunction

  task automatic tick(output bit rs);
    @(posedge clk);
    {e_as, e_mv, e_err, e_pto, e_flt} = '0;
    rs = rst || bus.new_game;
    if (rs) begin
      occ = '0;  e_cnt = 0;  e_pos = 0;  e_who = 0;  e_pt = 1'b1;  e_go = 1'b0;
    end
  endtask

  // One game, player first; returns as soon as a restart is sampled.
  task automatic game();
    bit rs;  bit player;  int t, pos;  logic [1:0] w;
    player = 1'b1;
    forever begin
      pos = 0;
      if (player) begin
        t = 0;
        forever begin
          tick(rs); if (rs) return;
          if (bus.p_confirm && legal(int'(bus.p_tick))) begin pos = int'(bus.p_tick); break; end
          if (bus.p_confirm) e_err = 1'b1;
          t++;
          if (t == P_TO) begin e_pto = 1'b1; pos = lowest(); break; end
        end
      end else begin
        tick(rs); if (rs) return;  // request cycle
        t = 0;
        forever begin
          tick(rs); if (rs) return;
          if (bus.ai_done) begin
            if (legal(int'(bus.ai_tick))) pos = int'(bus.ai_tick);
            else begin e_flt = 1'b1; pos = lowest(); end
            break;
          end
          t++;
          if (t == AI_TO) begin e_flt = 1'b1; pos = lowest(); break; end
        end
      end
      e_pt = 1'b0;
      tick(rs); if (rs) return;
      e_mv = 1'b1;  e_pos = pos;  e_who = player ? 1 : 2;  occ[pos] = 1'b1;  e_cnt++;
      w = 2'b00;
      for (int s = 0; s < SET; s++) begin tick(rs); if (rs) return; w = bus.winner; end
      if (w != 2'b00 || e_cnt == 9) begin
        e_go = 1'b1;
        forever begin tick(rs); if (rs) return; end
      end
      player = !player;
      if (player) e_pt = 1'b1; else e_as = 1'b1;
    end
  endtask

  initial begin : model
    bit rs;
    rs = 1'b0;
    while (!rs) tick(rs);
    active = 1'b1;
    forever game();
  end

  always @(negedge clk) if (active) begin
    chk("ai_start",    int'(bus.ai_start),    int'(e_as));
    chk("mv_valid",    int'(bus.mv_valid),    int'(e_mv));
    chk("mv_pos",      int'(bus.mv_pos),      e_pos);
    chk("mv_who",      int'(bus.mv_who),      e_who);
    chk("player_turn", int'(bus.player_turn), int'(e_pt));
    chk("move_cnt",    int'(bus.move_cnt),    e_cnt);
    chk("game_over",   int'(bus.game_over),   int'(e_go));
    chk("err_illegal", int'(bus.err_illegal), int'(e_err));
    chk("p_timeout",   int'(bus.p_timeout),   int'(e_pto));
    chk("ai_fault",    int'(bus.ai_fault),    int'(e_flt));
  end

  // ---------------- stimulus ----------------
  function automatic bit sig(input int s);
    case (s)
      S_MV:    return bus.mv_valid;
      S_AS:    return bus.ai_start;
      S_ERR:   return bus.err_illegal;
      S_PTO:   return bus.p_timeout;
      S_FLT:   return bus.ai_fault;
      S_PT:    return bus.player_turn;
      default: return bus.game_over;
    endcase
  endfunction

  task automatic wait_hi(input int s, input string name, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!sig(s) && n < 40);
    if (!sig(s)) begin
      checks++; failures++;
      $display("FAIL wait_%s: no pulse within %0d cycles", name, n);
    end
  endtask

  task automatic p_move(input int c);
    bus.p_tick = 4'(c);  bus.p_confirm = 1'b1;
    @(negedge clk);
    bus.p_confirm = 1'b0;
  endtask

  task automatic ai_move(input int c);
    @(negedge clk);
    bus.ai_tick = 4'(c);  bus.ai_done = 1'b1;
    @(negedge clk);
    bus.ai_done = 1'b0;
  endtask

  task automatic new_game_pulse();
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
  endtask

  task automatic expect_move(input string name, input int pos, input int who, input int cnt);
    int n;
    wait_hi(S_MV, name, n);
    chk({name, "_lat"}, n, 1);
    chk({name, "_pos"}, int'(bus.mv_pos), pos);
    chk({name, "_who"}, int'(bus.mv_who), who);
    chk({name, "_cnt"}, int'(bus.move_cnt), cnt);
  endtask

  initial begin : stim
    int n;
    bus.new_game = 1'b0;  bus.p_tick = '0;  bus.p_confirm = 1'b0;
    bus.ai_tick = '0;  bus.ai_done = 1'b0;  bus.winner = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_player_turn", int'(bus.player_turn), 1);
    chk("rst_move_cnt", int'(bus.move_cnt), 0);
    chk("rst_mv_valid", int'(bus.mv_valid), 0);
    rst = 1'b0;

    // basic exchange and latencies
    p_move(0);
    expect_move("p0", 0, 1, 1);
    wait_hi(S_AS, "ai_start", n);  chk("ai_start_lat", n, SET);
    ai_move(4);
    expect_move("a4", 4, 2, 2);
    wait_hi(S_PT, "pturn", n);  chk("pturn_lat", n, SET);

    // player timeout with 0 and 4 taken
    wait_hi(S_PTO, "p_timeout", n);  chk("p_timeout_lat", n, P_TO);
    expect_move("p_to", 1, 1, 3);

    // AI picks an occupied cell
    wait_hi(S_AS, "ai_start2", n);
    ai_move(0);
    chk("ai_bad_fault", int'(bus.ai_fault), 1);
    expect_move("a_bad", 2, 2, 4);

    // illegal player moves then a legal one
    wait_hi(S_PT, "pturn2", n);
    p_move(0);   chk("err_occupied", int'(bus.err_illegal), 1);
    p_move(11);  chk("err_range", int'(bus.err_illegal), 1);
    chk("err_cnt_held", int'(bus.move_cnt), 4);
    p_move(3);
    expect_move("p3", 3, 1, 5);

    // AI watchdog
    wait_hi(S_AS, "ai_start3", n);
    wait_hi(S_FLT, "watchdog", n);  chk("watchdog_lat", n, AI_TO + 1);
    expect_move("a_wd", 5, 2, 6);

    // winner reported during settle
    wait_hi(S_PT, "pturn3", n);
    p_move(6);
    expect_move("p6", 6, 1, 7);
    bus.winner = 2'b01;
    repeat (SET) @(negedge clk);
    chk("win_game_over", int'(bus.game_over), 1);
    chk("win_no_ai_start", int'(bus.ai_start), 0);
    bus.winner = 2'b00;
    p_move(7);  chk("done_no_err", int'(bus.err_illegal), 0);
    repeat (3) @(negedge clk);
    chk("done_cnt_held", int'(bus.move_cnt), 7);
    new_game_pulse();
    chk("ng_cnt", int'(bus.move_cnt), 0);
    chk("ng_pturn", int'(bus.player_turn), 1);
    chk("ng_game_over", int'(bus.game_over), 0);

    // new_game while AI is thinking, then a stale ai_done
    p_move(0);
    wait_hi(S_AS, "ai_start4", n);
    @(negedge clk);
    new_game_pulse();
    @(negedge clk);
    bus.ai_tick = 4'd3;  bus.ai_done = 1'b1;
    @(negedge clk);
    bus.ai_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("stale_no_mv", int'(bus.mv_valid), 0);
    chk("stale_cnt", int'(bus.move_cnt), 0);
    chk("stale_pturn", int'(bus.player_turn), 1);

    // full board; move 3 lands on watchdog expiry, move 4 on player expiry
    new_game_pulse();
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) begin
        wait_hi(S_PT, "pturn_full", n);
        if (i == 4) repeat (P_TO - 1) @(negedge clk);
        p_move(i);
        if (i == 4) chk("expiry_tie_pto", int'(bus.p_timeout), 0);
        expect_move("full_p", i, 1, i + 1);
      end else begin
        wait_hi(S_AS, "ai_full", n);
        if (i == 3) repeat (AI_TO - 1) @(negedge clk);
        ai_move(i);
        if (i == 3) chk("expiry_tie_fault", int'(bus.ai_fault), 0);
        expect_move("full_a", i, 2, i + 1);
      end
    end
    repeat (SET) @(negedge clk);
    chk("full_game_over", int'(bus.game_over), 1);
    chk("full_no_ai_start", int'(bus.ai_start), 0);
    chk("full_cnt", int'(bus.move_cnt), 9);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : guard
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end
endmodule
